// File: rtl/ex_div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) for the execute stage.
// Radix-2 restoring division, one quotient bit per cycle, single-cycle ready_o pulse.
module ex_div_unit #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [XLEN-1:0]       dividend_i,
  input  logic [XLEN-1:0]       divisor_i,
  input  logic [REG_ADDR_W-1:0] reg_waddr_i,
  input  logic                  flush_i,
  output logic [XLEN-1:0]       result_o,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic [REG_ADDR_W-1:0] reg_waddr_o
);

  localparam int              CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_END  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                  rem_sel_q;  // 1: REM/REMU, 0: DIV/DIVU
  logic                  q_neg_q;
  logic                  r_neg_q;
  logic [XLEN-1:0]       dq_q;       // dividend shifting out, quotient shifting in
  logic [XLEN-1:0]       rem_q;
  logic [XLEN-1:0]       divisor_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [REG_ADDR_W-1:0] waddr_q;

  logic load_en, step_en, finish_en;

  // Operand decode at start
  logic            is_signed, sign_a, sign_b, div_zero, overflow, special;
  logic [XLEN-1:0] abs_a, abs_b;

  assign is_signed = ~op_i[0];
  assign sign_a    = is_signed & dividend_i[XLEN-1];
  assign sign_b    = is_signed & divisor_i[XLEN-1];
  assign abs_a     = sign_a ? -dividend_i : dividend_i;
  assign abs_b     = sign_b ? -divisor_i  : divisor_i;
  assign div_zero  = (divisor_i == '0);
  assign overflow  = is_signed && (dividend_i == MIN_NEG) && (divisor_i == '1);
  assign special   = div_zero | overflow;

  // One restoring step on an XLEN+1-bit partial remainder
  logic [XLEN:0]   rem_shift, trial;
  logic            q_bit;
  logic [XLEN-1:0] rem_next;

  assign rem_shift = {rem_q, dq_q[XLEN-1]};
  assign trial     = rem_shift - {1'b0, divisor_q};
  assign q_bit     = ~trial[XLEN];
  assign rem_next  = q_bit ? trial[XLEN-1:0] : rem_shift[XLEN-1:0];

  logic [XLEN-1:0] quot_final, rem_final;
  assign quot_final = q_neg_q ? -dq_q  : dq_q;
  assign rem_final  = r_neg_q ? -rem_q : rem_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: the default assignment before the case keeps this block purely
  // combinational; a missing default on any path would infer a latch.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (start_i) state_d = special ? ST_END : ST_CALC;
        ST_CALC: if (cnt_q == LAST_IT) state_d = ST_END;
        ST_END:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o    = (state_q != ST_IDLE);
    load_en   = (state_q == ST_IDLE) && start_i && !flush_i;
    step_en   = (state_q == ST_CALC) && !flush_i;
    finish_en = (state_q == ST_END)  && !flush_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rem_sel_q   <= 1'b0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dq_q        <= '0;
      rem_q       <= '0;
      divisor_q   <= '0;
      cnt_q       <= '0;
      waddr_q     <= '0;
      result_o    <= '0;
      ready_o     <= 1'b0;
      reg_waddr_o <= '0;
    end else begin
      ready_o <= finish_en;

      if (load_en) begin
        rem_sel_q <= op_i[1];
        waddr_q   <= reg_waddr_i;
        cnt_q     <= '0;
        divisor_q <= abs_b;
        // Special cases preload the final quotient/remainder and skip CALC
        if (div_zero) begin
          dq_q    <= '1;
          rem_q   <= dividend_i;
          q_neg_q <= 1'b0;
          r_neg_q <= 1'b0;
        end else if (overflow) begin
          dq_q    <= MIN_NEG;
          rem_q   <= '0;
          q_neg_q <= 1'b0;
          r_neg_q <= 1'b0;
        end else begin
          dq_q    <= abs_a;
          rem_q   <= '0;
          q_neg_q <= sign_a ^ sign_b;
          r_neg_q <= sign_a;
        end
      end

      if (step_en) begin
        rem_q <= rem_next;
        dq_q  <= {dq_q[XLEN-2:0], q_bit};
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (finish_en) begin
        result_o    <= rem_sel_q ? rem_final : quot_final;
        reg_waddr_o <= waddr_q;
      end
    end
  end

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed testbench for ex_div_unit: latency, signed/unsigned results,
// special cases, flush, mid-operation start and asynchronous reset.
module tb_ex_div_unit;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = '0;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic [4:0]  reg_waddr_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] result_o;
  logic        ready_o;
  logic        busy_o;
  logic [4:0]  reg_waddr_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  ex_div_unit #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .start_i     (start_i),
    .op_i        (op_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .reg_waddr_i (reg_waddr_i),
    .flush_i     (flush_i),
    .result_o    (result_o),
    .ready_o     (ready_o),
    .busy_o      (busy_o),
    .reg_waddr_o (reg_waddr_o)
  );

  always #5 clk_i = ~clk_i;

  // Called just after a falling edge. Starts an op (E0 is the next rising edge)
  // and returns at the falling edge where ready_o is seen, with lat = edge index.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res, output logic [4:0] wa,
                        output int lat, output bit busy_ok);
    op_i = op; dividend_i = a; divisor_i = b; reg_waddr_i = rd; start_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0; dividend_i = 32'hA5A5_5A5A; divisor_i = 32'h0000_0003; reg_waddr_i = ~rd;
    lat = 0; busy_ok = 1'b1;
    while (!ready_o && lat < 100) begin
      if (!busy_o) busy_ok = 1'b0;
      @(negedge clk_i);
      lat++;
    end
    if (ready_o && busy_o) busy_ok = 1'b0;
    res = result_o; wa = reg_waddr_o;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({result_o, ready_o, busy_o, reg_waddr_o} !== 39'd0) begin
      errors++;
      $display("FAIL reset_outputs: got result=%h ready=%b busy=%b waddr=%0d, want all 0",
               result_o, ready_o, busy_o, reg_waddr_o);
    end
    @(negedge clk_i); rst_n_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_vectors(input string tag, input vec_t v[]);
    logic [31:0] res; logic [4:0] wa; int lat; bit busy_ok;
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, v[i].rd, res, wa, lat, busy_ok);
      checks++;
      if (lat !== v[i].lat) begin
        errors++;
        $display("FAIL %s_%s_latency: got %0d, want %0d", tag, v[i].name, lat, v[i].lat);
      end
      checks++;
      if (res !== v[i].exp) begin
        errors++;
        $display("FAIL %s_%s_result: got %h, want %h", tag, v[i].name, res, v[i].exp);
      end
      checks++;
      if (wa !== v[i].rd) begin
        errors++;
        $display("FAIL %s_%s_waddr: got %0d, want %0d", tag, v[i].name, wa, v[i].rd);
      end
      checks++;
      if (!busy_ok) begin
        errors++;
        $display("FAIL %s_%s_busy: busy_o not high for E0..E%0d then low", tag, v[i].name, v[i].lat);
      end
      @(negedge clk_i);
      checks++;
      if (ready_o !== 1'b0 || result_o !== v[i].exp) begin
        errors++;
        $display("FAIL %s_%s_pulse: got ready=%b result=%h, want ready=0 result=%h",
                 tag, v[i].name, ready_o, result_o, v[i].exp);
      end
    end
  endtask

  task automatic test_unsigned();
    vec_t v[2];
    v[0] = '{OP_DIVU, 32'd100, 32'd7, 5'd1, 32'd14, 33, "divu_100_7"};
    v[1] = '{OP_REMU, 32'd100, 32'd7, 5'd2, 32'd2,  33, "remu_100_7"};
    test_vectors("unsigned", v);
  endtask

  task automatic test_signed();
    vec_t v[3];
    v[0] = '{OP_DIV, 32'hFFFF_FFF9, 32'd2,         5'd3, 32'hFFFF_FFFD, 33, "div_m7_2"};
    v[1] = '{OP_REM, 32'hFFFF_FFF9, 32'd2,         5'd4, 32'hFFFF_FFFF, 33, "rem_m7_2"};
    v[2] = '{OP_REM, 32'd7,         32'hFFFF_FFFE, 5'd5, 32'd1,         33, "rem_7_m2"};
    test_vectors("signed", v);
  endtask

  task automatic test_div_zero();
    vec_t v[4];
    v[0] = '{OP_DIVU, 32'd5,         32'd0, 5'd6, 32'hFFFF_FFFF, 1, "divu_5_0"};
    v[1] = '{OP_REMU, 32'd5,         32'd0, 5'd7, 32'd5,         1, "remu_5_0"};
    v[2] = '{OP_DIV,  32'd0,         32'd0, 5'd8, 32'hFFFF_FFFF, 1, "div_0_0"};
    v[3] = '{OP_REM,  32'hFFFF_FFFB, 32'd0, 5'd9, 32'hFFFF_FFFB, 1, "rem_m5_0"};
    test_vectors("divzero", v);
  endtask

  task automatic test_overflow();
    vec_t v[3];
    v[0] = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1,  "div_min_m1"};
    v[1] = '{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0,         1,  "rem_min_m1"};
    v[2] = '{OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0,         33, "divu_min_m1"};
    test_vectors("overflow", v);
  endtask

  task automatic test_back_to_back();
    logic [31:0] res; logic [4:0] wa; int lat; bit busy_ok;
    run_op(OP_DIVU, 32'd81, 32'd9, 5'd13, res, wa, lat, busy_ok);
    // Second start issued in the ready_o cycle of the first
    run_op(OP_REMU, 32'd83, 32'd9, 5'd14, res, wa, lat, busy_ok);
    checks++;
    if (lat !== 33 || res !== 32'd2 || wa !== 5'd14) begin
      errors++;
      $display("FAIL b2b_second: got lat=%0d result=%h waddr=%0d, want 33/00000002/14", lat, res, wa);
    end
    @(negedge clk_i);
  endtask

  task automatic test_flush();
    logic [31:0] res; logic [4:0] wa; int lat; bit busy_ok; int seen;
    run_op(OP_DIVU, 32'd50, 32'd5, 5'd4, res, wa, lat, busy_ok);
    checks++;
    if (res !== 32'd10) begin
      errors++;
      $display("FAIL flush_setup: got %h, want 0000000a", res);
    end
    @(negedge clk_i);
    // Flush sampled at E10
    op_i = OP_DIVU; dividend_i = 32'd1000; divisor_i = 32'd3; reg_waddr_i = 5'd9; start_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i); start_i = 1'b0;
    repeat (9) @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 32'd10 || reg_waddr_o !== 5'd4) begin
      errors++;
      $display("FAIL flush_calc: got busy=%b ready=%b result=%h waddr=%0d, want 0/0/0000000a/4",
               busy_o, ready_o, result_o, reg_waddr_o);
    end
    seen = 0;
    repeat (40) begin @(negedge clk_i); if (ready_o || busy_o) seen++; end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL flush_calc_quiet: got %0d cycles with ready/busy, want 0", seen);
    end
    // Flush together with start in IDLE drops the start
    start_i = 1'b1; flush_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; flush_i = 1'b0;
    seen = 0;
    repeat (40) begin if (ready_o || busy_o) seen++; @(negedge clk_i); end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL flush_idle_start: got %0d cycles with ready/busy, want 0", seen);
    end
    // Flush sampled at E33 (END state) suppresses ready_o
    dividend_i = 32'd1000; divisor_i = 32'd3; reg_waddr_i = 5'd9; start_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i); start_i = 1'b0;
    repeat (32) @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 32'd10) begin
      errors++;
      $display("FAIL flush_end: got busy=%b ready=%b result=%h, want 0/0/0000000a",
               busy_o, ready_o, result_o);
    end
    @(negedge clk_i);
    run_op(OP_DIVU, 32'd1000, 32'd3, 5'd9, res, wa, lat, busy_ok);
    checks++;
    if (lat !== 33 || res !== 32'd333 || wa !== 5'd9) begin
      errors++;
      $display("FAIL flush_recover: got lat=%0d result=%h waddr=%0d, want 33/0000014d/9", lat, res, wa);
    end
    @(negedge clk_i);
  endtask

  task automatic test_midop_start_and_reset();
    int lat; int seen;
    op_i = OP_DIVU; dividend_i = 32'd100; divisor_i = 32'd7; reg_waddr_i = 5'd3; start_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i); start_i = 1'b0;
    repeat (4) @(negedge clk_i);
    // Stray request sampled at E5 while busy
    op_i = OP_DIVU; dividend_i = 32'd9; divisor_i = 32'd3; reg_waddr_i = 5'd7; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    lat = 5;
    while (!ready_o && lat < 100) begin @(negedge clk_i); lat++; end
    checks++;
    if (lat !== 33 || result_o !== 32'd14 || reg_waddr_o !== 5'd3) begin
      errors++;
      $display("FAIL midop_start: got lat=%0d result=%h waddr=%0d, want 33/0000000e/3",
               lat, result_o, reg_waddr_o);
    end
    @(negedge clk_i);
    // Asynchronous reset asserted just after E12
    op_i = OP_DIVU; dividend_i = 32'd100; divisor_i = 32'd7; reg_waddr_i = 5'd5; start_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i); start_i = 1'b0;
    repeat (11) @(negedge clk_i);
    @(posedge clk_i); #1;
    rst_n_i = 1'b0;
    #1;
    checks++;
    if ({result_o, ready_o, busy_o, reg_waddr_o} !== 39'd0) begin
      errors++;
      $display("FAIL reset_midop: got result=%h ready=%b busy=%b waddr=%0d, want all 0",
               result_o, ready_o, busy_o, reg_waddr_o);
    end
    @(negedge clk_i); rst_n_i = 1'b1;
    seen = 0;
    repeat (40) begin @(negedge clk_i); if (ready_o || busy_o) seen++; end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_quiet: got %0d cycles with ready/busy, want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_flush();
    test_midop_start_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
